// File: rtl/rng.sv
// Free-running pseudo-random source: 16-bit maximal-length LFSR mapped into [OFFSET, MAX_VALUE-1].
// Define RNG_NO_REPEAT_EN to guarantee that consecutive outputs differ.
module rng #(
   parameter int OFFSET    = 0,
   parameter int MAX_VALUE = 1223,
   parameter int SEED      = 42
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic [$clog2(MAX_VALUE)-1:0] random_value
);

   localparam int W = $clog2(MAX_VALUE);
   localparam int RANGE = MAX_VALUE - OFFSET;

   // A zero seed would lock the LFSR, so it is swapped for a known non-zero state
   localparam logic [15:0] SEED_INIT = (16'(SEED) == 16'd0) ? 16'hACE1 : 16'(SEED);
   localparam logic [15:0] RANGE16   = 16'(RANGE);
   localparam logic [W-1:0] OFFSET_W = W'(OFFSET);
   localparam logic [W-1:0] TOP_W    = W'(MAX_VALUE - 1);

   logic [15:0]  lfsr;
   logic [15:0]  lfsr_next;
   logic         fb;
   logic [15:0]  mod_val;
   logic [W-1:0] candidate;
   logic [W-1:0] mapped;

   always_comb begin
      fb        = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
      lfsr_next = {lfsr[14:0], fb};
      mod_val   = lfsr_next % RANGE16;
      // mod_val < RANGE, so the sum stays below MAX_VALUE and fits in W bits
      candidate = OFFSET_W + W'(mod_val);
`ifdef RNG_NO_REPEAT_EN
      mapped = candidate;
      if (candidate == random_value) begin
         mapped = (candidate == TOP_W) ? OFFSET_W : candidate + W'(1);
      end
`else
      mapped = candidate;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr         <= SEED_INIT;
         random_value <= OFFSET_W;
      end else begin
         lfsr         <= lfsr_next;
         random_value <= mapped;
      end
   end

endmodule

// File: tb/tb_rng.sv
// Self-checking bench for rng: three instances (default, zero seed, offset range) against a
// behavioural model, with randomized reset placement.
module tb_rng;

   logic clk;
   logic rst_n;
   logic [4:0] out_main;
   logic [4:0] out_seed0;
   logic [3:0] out_off;

   int checks = 0;
   int errors = 0;

   // model state, index 0 = dut, 1 = dut_seed0, 2 = dut_off
   int m_lfsr [3];
   int m_out  [3];
   int offs   [3] = '{0, 0, 5};
   int maxs   [3] = '{18, 18, 9};
   int seeds  [3] = '{42, 0, 42};

   rng #(.OFFSET(0), .MAX_VALUE(18), .SEED(42)) dut (
      .clk(clk), .rst_n(rst_n), .random_value(out_main));
   rng #(.OFFSET(0), .MAX_VALUE(18), .SEED(0)) dut_seed0 (
      .clk(clk), .rst_n(rst_n), .random_value(out_seed0));
   rng #(.OFFSET(5), .MAX_VALUE(9), .SEED(42)) dut_off (
      .clk(clk), .rst_n(rst_n), .random_value(out_off));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int model_seed(int s);
      int v;
      v = s & 16'hFFFF;
      return (v == 0) ? 16'hACE1 : v;
   endfunction

   // Polynomial x^16+x^14+x^13+x^11+1: term x^k taps state bit k-1
   function automatic int model_next(int s);
      int taps [4] = '{16, 14, 13, 11};
      int f;
      f = 0;
      foreach (taps[k]) f = f ^ ((s >> (taps[k] - 1)) & 1);
      return ((s * 2) + f) % 65536;
   endfunction

   function automatic int model_map(int st, int off, int mx, int prev);
      int c;
      c = off + (st % (mx - off));
`ifdef RNG_NO_REPEAT_EN
      if (c == prev) begin
         c = c + 1;
         if (c > mx - 1) c = off;
      end
`endif
      return c;
   endfunction

   function automatic int act_out(int i);
      case (i)
         0:       return int'(out_main);
         1:       return int'(out_seed0);
         default: return int'(out_off);
      endcase
   endfunction

   function automatic int act_lfsr(int i);
      case (i)
         0:       return int'(dut.lfsr);
         1:       return int'(dut_seed0.lfsr);
         default: return int'(dut_off.lfsr);
      endcase
   endfunction

   task automatic step();
      logic r;
      r = rst_n;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         if (!r) begin
            m_lfsr[i] = model_seed(seeds[i]);
            m_out[i]  = offs[i];
         end else begin
            m_lfsr[i] = model_next(m_lfsr[i]);
            m_out[i]  = model_map(m_lfsr[i], offs[i], maxs[i], m_out[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++;
      if (int'(out_main) !== 0) begin
         errors++;
         $display("[TB] FAIL reset_out: got %0d want 0", out_main);
      end
      checks++;
      if (int'(dut.lfsr) !== 16'h002A) begin
         errors++;
         $display("[TB] FAIL reset_lfsr: got %h want 002a", dut.lfsr);
      end
      checks++;
      if (int'(dut_seed0.lfsr) !== 16'hACE1) begin
         errors++;
         $display("[TB] FAIL reset_seed0_lfsr: got %h want ace1", dut_seed0.lfsr);
      end
      checks++;
      if (int'(out_off) !== 5) begin
         errors++;
         $display("[TB] FAIL reset_offset_out: got %0d want 5", out_off);
      end
   endtask

   task automatic test_release();
      int exp_out  [4] = '{12, 6, 12, 6};
      int exp_lfsr [4] = '{16'h0054, 16'h00A8, 16'h0150, 16'h02A0};
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if (int'(out_main) !== exp_out[k]) begin
            errors++;
            $display("[TB] FAIL release_out[%0d]: got %0d want %0d", k, out_main, exp_out[k]);
         end
         checks++;
         if (int'(dut.lfsr) !== exp_lfsr[k]) begin
            errors++;
            $display("[TB] FAIL release_lfsr[%0d]: got %h want %h", k, dut.lfsr, exp_lfsr[k]);
         end
      end
   endtask

   task automatic test_range();
      bit seen_main [18];
      bit seen_off  [9];
      bit seen_s0   [18];
      int bad_main, bad_off, mism, repeats, first_return;
      int n_main, n_off, n_s0;
      int p0, p1, p2;
      bad_main = 0; bad_off = 0; mism = 0; repeats = 0; first_return = 0;
      p0 = int'(out_main); p1 = int'(out_seed0); p2 = int'(out_off);
      // four steps since reset were taken by test_release
      for (int s = 5; s <= 65535; s++) begin
         step();
         if (int'(out_main) < 18) seen_main[out_main] = 1'b1; else bad_main++;
         if (int'(out_off) >= 5 && int'(out_off) <= 8) seen_off[out_off] = 1'b1; else bad_off++;
         if (int'(out_seed0) < 18) seen_s0[out_seed0] = 1'b1;
         for (int i = 0; i < 3; i++) begin
            if (act_out(i) !== m_out[i] || act_lfsr(i) !== m_lfsr[i]) begin
               if (mism == 0)
                  $display("[TB] first model divergence: inst %0d step %0d out %0d want %0d lfsr %h want %h",
                           i, s, act_out(i), m_out[i], act_lfsr(i), m_lfsr[i]);
               mism++;
            end
         end
         if (int'(out_main) == p0 || int'(out_seed0) == p1 || int'(out_off) == p2) repeats++;
         p0 = int'(out_main); p1 = int'(out_seed0); p2 = int'(out_off);
         if (first_return == 0 && int'(dut.lfsr) == 16'h002A) first_return = s;
      end
      n_main = 0; n_off = 0; n_s0 = 0;
      foreach (seen_main[v]) if (seen_main[v]) n_main++;
      foreach (seen_off[v]) if (seen_off[v]) n_off++;
      foreach (seen_s0[v]) if (seen_s0[v]) n_s0++;
      checks++;
      if (bad_main !== 0) begin
         errors++;
         $display("[TB] FAIL range_upper: %0d outputs >= 18, want 0", bad_main);
      end
      checks++;
      if (n_main !== 18) begin
         errors++;
         $display("[TB] FAIL range_coverage: %0d distinct values, want 18", n_main);
      end
      checks++;
      if (bad_off !== 0) begin
         errors++;
         $display("[TB] FAIL offset_range: %0d outputs outside 5..8, want 0", bad_off);
      end
      checks++;
      if (n_off !== 4) begin
         errors++;
         $display("[TB] FAIL offset_coverage: %0d distinct values, want 4", n_off);
      end
      checks++;
      if (n_s0 < 2) begin
         errors++;
         $display("[TB] FAIL seed0_stuck: %0d distinct values, want >1", n_s0);
      end
      checks++;
      if (first_return !== 65535) begin
         errors++;
         $display("[TB] FAIL lfsr_period: returned to 002a at step %0d, want 65535", first_return);
      end
      checks++;
      if (mism !== 0) begin
         errors++;
         $display("[TB] FAIL range_model: %0d divergent samples, want 0", mism);
      end
`ifdef RNG_NO_REPEAT_EN
      checks++;
      if (repeats !== 0) begin
         errors++;
         $display("[TB] FAIL no_repeat: %0d consecutive repeats, want 0", repeats);
      end
`endif
   endtask

   task automatic test_mid_reset();
      int mism;
      mism = 0;
      for (int s = 0; s < 500; s++) begin
         step();
         for (int i = 0; i < 3; i++)
            if (act_out(i) !== m_out[i]) mism++;
      end
      checks++;
      if (mism !== 0) begin
         errors++;
         $display("[TB] FAIL mid_run_model: %0d divergent samples, want 0", mism);
      end
      rst_n = 1'b0;
      step();
      checks++;
      if (int'(out_main) !== 0 || int'(dut.lfsr) !== 16'h002A) begin
         errors++;
         $display("[TB] FAIL mid_reset: out %0d lfsr %h, want 0 / 002a", out_main, dut.lfsr);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (int'(out_main) !== 12) begin
         errors++;
         $display("[TB] FAIL mid_restart0: got %0d want 12", out_main);
      end
      step();
      checks++;
      if (int'(out_main) !== 6) begin
         errors++;
         $display("[TB] FAIL mid_restart1: got %0d want 6", out_main);
      end
   endtask

   task automatic test_random_resets();
      int run_len, hold;
      for (int it = 0; it < 5; it++) begin
         run_len = int'($urandom_range(1, 150));
         hold    = int'($urandom_range(1, 3));
         for (int s = 0; s < run_len; s++) begin
            step();
            for (int i = 0; i < 3; i++) begin
               checks++;
               if (act_out(i) !== m_out[i]) begin
                  errors++;
                  $display("[TB] FAIL rand_run inst%0d: got %0d want %0d", i, act_out(i), m_out[i]);
               end
            end
         end
         rst_n = 1'b0;
         for (int h = 0; h < hold; h++) step();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (act_out(i) !== offs[i] || act_lfsr(i) !== model_seed(seeds[i])) begin
               errors++;
               $display("[TB] FAIL rand_reset inst%0d: out %0d lfsr %h want %0d / %h",
                        i, act_out(i), act_lfsr(i), offs[i], model_seed(seeds[i]));
            end
         end
         rst_n = 1'b1;
         for (int s = 0; s < 4; s++) begin
            step();
            for (int i = 0; i < 3; i++) begin
               checks++;
               if (act_out(i) !== m_out[i]) begin
                  errors++;
                  $display("[TB] FAIL rand_restart inst%0d: got %0d want %0d", i, act_out(i), m_out[i]);
               end
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      test_reset();
      test_release();
      test_range();
      test_mid_reset();
      test_random_resets();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
